attn_score_sched: RTL and testbench

ATTN_SCORE_SCHED -- requirements
Module: attn_score_sched

---
 rtl/attn_score_sched_if.sv | 47 ++++
 rtl/attn_score_sched.sv | 154 +++++++++++++++
 tb/tb_attn_score_sched.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/attn_score_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : attn_score_sched_if
//  Purpose  : Job control plus q/k/engine/result/score streams of the
//             attention score scheduler.
//  Revision : 1.0  initial release
// ============================================================================
interface attn_score_sched_if #(
   parameter int NK_W = 4
);
   logic            start;
   logic [NK_W-1:0] nkeys;
   logic            q_vld;
   logic            q_rdy;
   logic [7:0]      q_data;
   logic            k_vld;
   logic            k_rdy;
   logic [7:0]      k_data;
   logic            eng_vld;
   logic            eng_rdy;
   logic [7:0]      eng_data;
   logic            res_vld;
   logic            res_rdy;
   logic [8:0]      res_data;
   logic            score_vld;
   logic            score_rdy;
   logic [8:0]      score_data;
   logic            score_last;
   logic [12:0]     sum_data;
   logic            busy;
   logic            done;

   modport slave (
      input  start, nkeys, q_vld, q_data, k_vld, k_data, eng_rdy,
             res_vld, res_data, score_rdy,
      output q_rdy, k_rdy, eng_vld, eng_data, res_rdy, score_vld,
             score_data, score_last, sum_data, busy, done
   );

   modport master (
      output start, nkeys, q_vld, q_data, k_vld, k_data, eng_rdy,
             res_vld, res_data, score_rdy,
      input  q_rdy, k_rdy, eng_vld, eng_data, res_rdy, score_vld,
             score_data, score_last, sum_data, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/attn_score_sched.sv
`default_nettype none
// ============================================================================
//  Module   : attn_score_sched
//  Purpose  : Credit-limited scheduler interleaving a buffered query with key
//             streams into a MAC/exp engine; forwards engine scores.
//             Macro ATTN_SCHED_SUM_EN builds the score-sum accumulator.
//  Revision : 1.0  initial release
// ============================================================================
module attn_score_sched #(
   parameter int CREDITS = 2,
   parameter int NK_W    = 4
) (
   input  wire logic          clk,
   input  wire logic          rst,
   attn_score_sched_if.slave  bus
);

   localparam logic [2:0]      c_IDLE    = 3'd0;
   localparam logic [2:0]      c_LOADQ   = 3'd1;
   localparam logic [2:0]      c_ISSUE   = 3'd2;
   localparam logic [2:0]      c_DRAIN   = 3'd3;
   localparam logic [2:0]      c_DONE    = 3'd4;
   localparam logic [1:0]      c_CREDITS = 2'(CREDITS);
   localparam logic [NK_W-1:0] c_ONE     = NK_W'(1);

   logic [2:0]      r_state;
   logic [2:0]      w_next;
   logic [NK_W-1:0] r_nkeys;
   logic [NK_W-1:0] r_key;
   logic [NK_W-1:0] r_res;
   logic [2:0]      r_beat;
   logic [1:0]      r_credit;
   logic [7:0]      r_qbuf [4];

   logic w_q_xfer;
   logic w_eng_xfer;
   logic w_q0_xfer;
   logic w_res_xfer;
   logic w_outstanding;
   logic w_last_key;
   logic w_last_res;
   logic w_start;

   assign w_start       = (r_state == c_IDLE) && bus.start;
   assign w_q_xfer      = bus.q_vld && bus.q_rdy;
   assign w_eng_xfer    = bus.eng_vld && bus.eng_rdy;
   assign w_q0_xfer     = w_eng_xfer && (r_beat == 3'd0);
   assign w_outstanding = r_credit < c_CREDITS;
   assign w_res_xfer    = bus.res_vld && bus.res_rdy;
   assign w_last_key    = r_key == (r_nkeys - c_ONE);
   assign w_last_res    = r_res == (r_nkeys - c_ONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE:  if (bus.start) w_next = (bus.nkeys == '0) ? c_DONE : c_LOADQ;
         c_LOADQ: if (w_q_xfer && (r_beat == 3'd3)) w_next = c_ISSUE;
         c_ISSUE: if (w_eng_xfer && (r_beat == 3'd7) && w_last_key) w_next = c_DRAIN;
         c_DRAIN: if (w_res_xfer && w_last_res) w_next = c_DONE;
         c_DONE:  w_next = c_IDLE;
         default: w_next = c_IDLE;
      endcase
   end

   // Odd beats are key bytes passed straight through; even beats replay qbuf.
   always_comb begin
      bus.q_rdy    = 1'b0;
      bus.k_rdy    = 1'b0;
      bus.eng_vld  = 1'b0;
      bus.eng_data = 8'h00;
      case (r_state)
         c_LOADQ: bus.q_rdy = 1'b1;
         c_ISSUE: begin
            if (r_beat[0]) begin
               bus.eng_vld  = bus.k_vld;
               bus.eng_data = bus.k_data;
               bus.k_rdy    = bus.eng_rdy;
            end else begin
               bus.eng_vld  = (r_beat != 3'd0) || (r_credit != 2'd0);
               bus.eng_data = r_qbuf[r_beat[2:1]];
            end
         end
         default: ;
      endcase
   end

   assign bus.busy       = r_state != c_IDLE;
   assign bus.done       = r_state == c_DONE;
   assign bus.score_data = bus.res_data;
   assign bus.score_vld  = bus.res_vld && w_outstanding;
   assign bus.res_rdy    = bus.score_rdy && w_outstanding;
   assign bus.score_last = w_last_res;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_nkeys  <= '0;
         r_key    <= '0;
         r_res    <= '0;
         r_beat   <= 3'd0;
         r_credit <= c_CREDITS;
         for (int i = 0; i < 4; i++) r_qbuf[i] <= 8'h00;
      end else begin
         if (w_start) begin
            r_nkeys <= bus.nkeys;
            r_key   <= '0;
            r_res   <= '0;
            r_beat  <= 3'd0;
         end
         if (w_q_xfer) begin
            r_qbuf[r_beat[1:0]] <= bus.q_data;
            r_beat              <= (r_beat == 3'd3) ? 3'd0 : r_beat + 3'd1;
         end
         if (w_eng_xfer) begin
            r_beat <= r_beat + 3'd1;
            if (r_beat == 3'd7) r_key <= r_key + c_ONE;
         end
         if (w_res_xfer) r_res <= r_res + c_ONE;
         // A credit taken and returned in the same cycle cancels out.
         case ({w_q0_xfer, w_res_xfer})
            2'b10:   r_credit <= r_credit - 2'd1;
            2'b01:   r_credit <= r_credit + 2'd1;
            default: ;
         endcase
      end
   end

`ifdef ATTN_SCHED_SUM_EN
   logic [12:0] r_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum <= 13'd0;
      end else if (w_start) begin
         r_sum <= 13'd0;
      end else if (w_res_xfer) begin
         r_sum <= r_sum + {4'd0, bus.res_data};
      end
   end

   assign bus.sum_data = r_sum;
`else
   assign bus.sum_data = 13'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_attn_score_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_attn_score_sched
//  Purpose  : Directed self-checking bench for attn_score_sched with a
//             fixed-latency engine model and recorded stream logs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_attn_score_sched;

   localparam int CREDITS = 2;
   localparam int NK_W    = 4;
`ifdef ATTN_SCHED_SUM_EN
   localparam bit SUM_EN = 1'b1;
`else
   localparam bit SUM_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   attn_score_sched_if #(.NK_W(NK_W)) ifc ();

   attn_score_sched #(.CREDITS(CREDITS), .NK_W(NK_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   logic [7:0] q_arr   [256];
   logic [7:0] k_arr   [256];
   logic [8:0] res_tab [256];
   int   q_lim     = 0;
   int   k_lim     = 0;
   int   res_allow = 100000;
   logic q_on      = 1'b1;
   logic k_on      = 1'b1;
   logic eng_on    = 1'b1;
   logic score_on  = 1'b1;

   int         q_xfer    = 0;
   int         k_xfer    = 0;
   int         eng_cnt   = 0;
   int         eng_phase = 0;
   int         pending   = 0;
   int         res_cnt   = 0;
   int         score_cnt = 0;
   int         last_cnt  = 0;
   int         done_cnt  = 0;
   logic [7:0] eng_log   [1024];
   logic [8:0] score_log [256];
   logic       last_log  [256];

   int n_run  = 0;
   int n_fail = 0;

   assign ifc.q_vld     = q_on && (q_xfer < q_lim);
   assign ifc.q_data    = q_arr[q_xfer[7:0]];
   assign ifc.k_vld     = k_on && (k_xfer < k_lim);
   assign ifc.k_data    = k_arr[k_xfer[7:0]];
   assign ifc.eng_rdy   = eng_on;
   assign ifc.res_vld   = (pending > 0) && (res_cnt < res_allow);
   assign ifc.res_data  = res_tab[res_cnt[7:0]];
   assign ifc.score_rdy = score_on;

   // Engine model: one result becomes available after every 8th operand beat.
   always @(posedge clk) begin
      if (rst) begin
         eng_phase <= 0;
         pending   <= 0;
      end else begin
         if (ifc.q_vld && ifc.q_rdy) q_xfer <= q_xfer + 1;
         if (ifc.k_vld && ifc.k_rdy) k_xfer <= k_xfer + 1;
         if (ifc.eng_vld && ifc.eng_rdy) begin
            eng_log[eng_cnt[9:0]] <= ifc.eng_data;
            eng_cnt   <= eng_cnt + 1;
            eng_phase <= (eng_phase == 7) ? 0 : eng_phase + 1;
         end
         pending <= pending + ((ifc.eng_vld && ifc.eng_rdy && eng_phase == 7) ? 1 : 0)
                            - ((ifc.res_vld && ifc.res_rdy) ? 1 : 0);
         if (ifc.res_vld && ifc.res_rdy) res_cnt <= res_cnt + 1;
         if (ifc.score_vld && ifc.score_rdy) begin
            score_log[score_cnt[7:0]] <= ifc.score_data;
            last_log[score_cnt[7:0]]  <= ifc.score_last;
            score_cnt <= score_cnt + 1;
            if (ifc.score_last) last_cnt <= last_cnt + 1;
         end
         if (ifc.done) done_cnt <= done_cnt + 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_q(input logic [31:0] v);
      for (int i = 0; i < 4; i++) q_arr[q_lim + i] = v[8*i +: 8];
      q_lim = q_lim + 4;
   endtask

   task automatic push_k(input logic [31:0] v);
      for (int i = 0; i < 4; i++) k_arr[k_lim + i] = v[8*i +: 8];
      k_lim = k_lim + 4;
   endtask

   task automatic start_job(input logic [NK_W-1:0] n);
      ifc.nkeys = n;
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget && ifc.done !== 1'b1; i++) @(negedge clk);
      chk(tag, ifc.done, 1);
      @(negedge clk);
   endtask

   int be, bs, br, bd, bq, bk, bl;

   initial begin
      for (int i = 0; i < 256; i++) begin
         q_arr[i]   = 8'h00;
         k_arr[i]   = 8'h00;
         res_tab[i] = 9'h000;
      end
      ifc.start = 1'b0;
      ifc.nkeys = '0;
      tick(3);
      chk("rst_busy",      ifc.busy,      0);
      chk("rst_done",      ifc.done,      0);
      chk("rst_eng_vld",   ifc.eng_vld,   0);
      chk("rst_q_rdy",     ifc.q_rdy,     0);
      chk("rst_k_rdy",     ifc.k_rdy,     0);
      chk("rst_res_rdy",   ifc.res_rdy,   0);
      chk("rst_score_vld", ifc.score_vld, 0);
      chk("rst_sum",       ifc.sum_data,  0);
      rst = 1'b0;
      tick(1);

      // Single key: q0*k0 = 0x40*0x40, engine answers 0x050
      be = eng_cnt; bs = score_cnt; bd = done_cnt;
      push_q(32'h0000_0040);
      push_k(32'h0000_0040);
      res_tab[res_cnt] = 9'h050;
      start_job(1);
      chk("t1_busy", ifc.busy, 1);
      wait_done("t1_done", 100);
      for (int i = 0; i < 8; i++) chk("t1_beat", eng_log[be + i], (i < 2) ? 8'h40 : 8'h00);
      chk("t1_nbeats",   eng_cnt - be,    8);
      chk("t1_nscore",   score_cnt - bs,  1);
      chk("t1_score",    score_log[bs],   9'h050);
      chk("t1_last",     last_log[bs],    1);
      chk("t1_ndone",    done_cnt - bd,   1);
      chk("t1_done_low", ifc.done,        0);
      chk("t1_sum",      ifc.sum_data,    SUM_EN ? 32'h050 : 32'h0);

      // Results withheld: two credits allow exactly two keys (16 beats)
      be = eng_cnt; bs = score_cnt; br = res_cnt;
      res_allow = res_cnt;
      push_q(32'h0403_0201);
      for (int i = 0; i < 4; i++) begin
         push_k(32'h1122_3344 + i);
         res_tab[res_cnt + i] = 9'h100 + 9'(i);
      end
      start_job(4);
      tick(60);
      chk("t2_beats_held", eng_cnt - be, 16);
      chk("t2_eng_vld_lo", ifc.eng_vld,  0);
      chk("t2_res_none",   res_cnt - br, 0);
      res_allow = res_cnt + 1;
      tick(1);
      chk("t2_res_one",    res_cnt - br, 1);
      chk("t2_q0_vld",     ifc.eng_vld,  1);
      chk("t2_q0_data",    ifc.eng_data, 8'h01);
      res_allow = 100000;
      wait_done("t2_done", 200);
      chk("t2_nbeats", eng_cnt - be,   32);
      chk("t2_nscore", score_cnt - bs, 4);
      for (int i = 0; i < 4; i++) chk("t2_score", score_log[bs + i], 9'h100 + 9'(i));
      chk("t2_last0", last_log[bs],     0);
      chk("t2_last3", last_log[bs + 3], 1);

      // Score back-pressure for 10 cycles after the first key is issued
      be = eng_cnt; bs = score_cnt;
      push_q(32'h0A0B_0C0D);
      for (int i = 0; i < 3; i++) push_k(32'h5060_7080 + i);
      res_tab[res_cnt]     = 9'h0AA;
      res_tab[res_cnt + 1] = 9'h155;
      res_tab[res_cnt + 2] = 9'h1F0;
      start_job(3);
      for (int i = 0; i < 100 && (eng_cnt - be) < 8; i++) @(negedge clk);
      score_on = 1'b0;
      br = res_cnt;
      tick(10);
      chk("t3_res_rdy",   ifc.res_rdy,   0);
      chk("t3_score_vld", ifc.score_vld, 1);
      chk("t3_no_res",    res_cnt - br,  0);
      chk("t3_beats",     eng_cnt - be,  16);
      score_on = 1'b1;
      wait_done("t3_done", 200);
      chk("t3_nscore", score_cnt - bs,    3);
      chk("t3_s0",     score_log[bs],     9'h0AA);
      chk("t3_s1",     score_log[bs + 1], 9'h155);
      chk("t3_s2",     score_log[bs + 2], 9'h1F0);
      chk("t3_last",   last_log[bs + 2],  1);

      // Fifteen keys of full-scale results: sum = 15 * 0x1FF
      bs = score_cnt; bl = last_cnt;
      push_q(32'h7F7F_7F7F);
      for (int i = 0; i < 15; i++) begin
         push_k(32'h7F7F_7F7F);
         res_tab[res_cnt + i] = 9'h1FF;
      end
      start_job(15);
      wait_done("t4_done", 600);
      chk("t4_nscore", score_cnt - bs,    15);
      chk("t4_s14",    score_log[bs + 14], 9'h1FF);
      chk("t4_last14", last_log[bs + 14], 1);
      chk("t4_nlast",  last_cnt - bl,     1);
      tick(3);
      chk("t4_sum",    ifc.sum_data,      SUM_EN ? 32'h1DF1 : 32'h0);

      // Zero-key job skips straight to DONE
      bq = q_xfer; bk = k_xfer; be = eng_cnt;
      start_job(0);
      chk("t5_done",    ifc.done, 1);
      chk("t5_busy",    ifc.busy, 1);
      tick(1);
      chk("t5_done_lo", ifc.done, 0);
      chk("t5_idle",    ifc.busy, 0);
      chk("t5_noxfer",  (q_xfer - bq) + (k_xfer - bk) + (eng_cnt - be), 0);

      // A start while busy must not restart or re-size the job
      bs = score_cnt; bd = done_cnt;
      q_on = 1'b0;
      push_q(32'h0000_0040);
      push_k(32'h0000_0040);
      res_tab[res_cnt] = 9'h033;
      start_job(1);
      tick(2);
      start_job(5);
      q_on = 1'b1;
      wait_done("t5b_done", 100);
      chk("t5b_nscore", score_cnt - bs,  1);
      chk("t5b_score",  score_log[bs],   9'h033);
      chk("t5b_ndone",  done_cnt - bd,   1);
      tick(3);
      chk("t5b_idle",   ifc.busy,        0);

      // Reset on a key beat aborts the job, then a fresh job runs
      push_q(32'h0102_0304);
      push_k(32'h0506_0708);
      push_k(32'h090A_0B0C);
      start_job(2);
      for (int i = 0; i < 100 && ifc.k_rdy !== 1'b1; i++) @(negedge clk);
      chk("t6_kbeat", ifc.k_rdy, 1);
      rst = 1'b1;
      tick(1);
      chk("t6_eng_vld",   ifc.eng_vld,   0);
      chk("t6_q_rdy",     ifc.q_rdy,     0);
      chk("t6_k_rdy",     ifc.k_rdy,     0);
      chk("t6_res_rdy",   ifc.res_rdy,   0);
      chk("t6_score_vld", ifc.score_vld, 0);
      chk("t6_busy",      ifc.busy,      0);
      rst = 1'b0;
      q_lim = q_xfer;
      k_lim = k_xfer;
      be = eng_cnt;
      tick(5);
      chk("t6_no_beats", eng_cnt - be, 0);
      bs = score_cnt;
      push_q(32'h0000_0020);
      push_k(32'h0000_0030);
      res_tab[res_cnt] = 9'h0F0;
      start_job(1);
      wait_done("t6_done", 100);
      chk("t6_b0",     eng_log[be],     8'h20);
      chk("t6_b1",     eng_log[be + 1], 8'h30);
      chk("t6_nbeats", eng_cnt - be,    8);
      chk("t6_score",  score_log[bs],   9'h0F0);
      chk("t6_last",   last_log[bs],    1);
      chk("t6_sum",    ifc.sum_data,    SUM_EN ? 32'h0F0 : 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
